// File: rtl/vend_payout_controller.sv
// Payout sequencer: runs the item motor, then pays change as 20/10/5 coins through one shared ejector.
// It tracks hopper inventory, accumulates unpaid change as owed, and latches a sticky fault on hopper timeout.
module vend_payout_controller #(
  parameter int MOTOR_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 16,
  parameter int HOPPER_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_item,
  input  logic [7:0] req_change,
  output logic       motor_en,
  output logic [1:0] motor_item,
  output logic       eject_valid,
  output logic [1:0] eject_coin,
  input  logic       eject_ack,
  input  logic       refill,
  output logic [3:0] cnt5,
  output logic [3:0] cnt10,
  output logic [3:0] cnt20,
  output logic [7:0] owed,
  output logic       fault,
  output logic       done,
  output logic [2:0] state_out
);

  // state  | meaning
  // IDLE   | waiting for a request; refill honoured
  // MOTOR  | dispense motor running for MOTOR_CYCLES
  // SELECT | greedy pick of the next coin, or settle the remainder
  // EJECT  | coin presented; wait for ack or time out
  // DONE   | one-cycle completion pulse
  // FAULT  | hopper timed out; held until refill
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MOTOR  = 3'd1,
    S_SELECT = 3'd2,
    S_EJECT  = 3'd3,
    S_DONE   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam int TMAX = (MOTOR_CYCLES > ACK_TIMEOUT) ? MOTOR_CYCLES : ACK_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [3:0] DEPTH = 4'(HOPPER_DEPTH);

  state_t        state, state_n;
  logic [1:0]    item, item_n;
  logic [7:0]    rem, rem_n;
  logic [1:0]    coin, coin_n;
  logic [TW-1:0] timer, timer_n;
  logic [3:0]    cnt5_n, cnt10_n, cnt20_n;
  logic [7:0]    owed_n;
  logic          fault_n;
  logic [8:0]    owed_sum;
  logic [7:0]    owed_sat;

  function automatic logic [7:0] coin_value(input logic [1:0] c);
    case (c)
      2'b01:   coin_value = 8'd5;
      2'b10:   coin_value = 8'd10;
      2'b11:   coin_value = 8'd20;
      default: coin_value = 8'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      item  <= '0;
      rem   <= '0;
      coin  <= '0;
      timer <= '0;
      cnt5  <= DEPTH;
      cnt10 <= DEPTH;
      cnt20 <= DEPTH;
      owed  <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      item  <= item_n;
      rem   <= rem_n;
      coin  <= coin_n;
      timer <= timer_n;
      cnt5  <= cnt5_n;
      cnt10 <= cnt10_n;
      cnt20 <= cnt20_n;
      owed  <= owed_n;
      fault <= fault_n;
    end
  end

  always_comb begin
    state_n  = state;
    item_n   = item;
    rem_n    = rem;
    coin_n   = coin;
    timer_n  = timer;
    cnt5_n   = cnt5;
    cnt10_n  = cnt10;
    cnt20_n  = cnt20;
    owed_n   = owed;
    fault_n  = fault;
    owed_sum = {1'b0, owed} + {1'b0, rem};
    owed_sat = owed_sum[8] ? 8'hFF : owed_sum[7:0];

    case (state)
      S_IDLE: begin
        if (!refill && req_valid) begin
          item_n = req_item;
          rem_n  = req_change;
          if (req_item != 2'd0) begin
            timer_n = TW'(MOTOR_CYCLES - 1);
            state_n = S_MOTOR;
          end else begin
            state_n = S_SELECT;
          end
        end
      end
      S_MOTOR: begin
        if (timer == '0) state_n = S_SELECT;
        else             timer_n = timer - 1'b1;
      end
      S_SELECT: begin
        timer_n = TW'(ACK_TIMEOUT - 1);
        if (rem >= 8'd20 && cnt20 != 4'd0) begin
          coin_n  = 2'b11;
          state_n = S_EJECT;
        end else if (rem >= 8'd10 && cnt10 != 4'd0) begin
          coin_n  = 2'b10;
          state_n = S_EJECT;
        end else if (rem >= 8'd5 && cnt5 != 4'd0) begin
          coin_n  = 2'b01;
          state_n = S_EJECT;
        end else begin
          // Whatever cannot be paid from stock is recorded and the payout closes.
          if (rem != 8'd0) owed_n = owed_sat;
          rem_n   = '0;
          state_n = S_DONE;
        end
      end
      S_EJECT: begin
        if (eject_ack) begin
          rem_n = rem - coin_value(coin);
          case (coin)
            2'b01:   cnt5_n  = cnt5 - 1'b1;
            2'b10:   cnt10_n = cnt10 - 1'b1;
            2'b11:   cnt20_n = cnt20 - 1'b1;
            default: ;
          endcase
          state_n = S_SELECT;
        end else if (timer == '0) begin
          owed_n  = owed_sat;
          fault_n = 1'b1;
          rem_n   = '0;
          state_n = S_FAULT;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_FAULT: ;
      default: state_n = S_IDLE;
    endcase

    if (refill && (state == S_IDLE || state == S_FAULT)) begin
      cnt5_n  = DEPTH;
      cnt10_n = DEPTH;
      cnt20_n = DEPTH;
      owed_n  = '0;
      fault_n = 1'b0;
      state_n = S_IDLE;
    end
  end

  assign req_ready   = (state == S_IDLE);
  assign motor_en    = (state == S_MOTOR);
  assign motor_item  = motor_en ? item : 2'd0;
  assign eject_valid = (state == S_EJECT);
  assign eject_coin  = eject_valid ? coin : 2'd0;
  assign done        = (state == S_DONE);
  assign state_out   = state;

endmodule

// File: tb/tb_vend_payout_controller.sv
// Bench for vend_payout_controller: a queue-based scoreboard fed by a greedy payout model,
// directed boundary scenarios, and a randomized transaction phase.
module tb_vend_payout_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_item;
  logic [7:0] req_change;
  logic       motor_en;
  logic [1:0] motor_item;
  logic       eject_valid;
  logic [1:0] eject_coin;
  logic       eject_ack;
  logic       refill;
  logic [3:0] cnt5, cnt10, cnt20;
  logic [7:0] owed;
  logic       fault;
  logic       done;
  logic [2:0] state_out;

  vend_payout_controller #(.MOTOR_CYCLES(4), .ACK_TIMEOUT(16), .HOPPER_DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_item(req_item), .req_change(req_change), .motor_en(motor_en), .motor_item(motor_item),
    .eject_valid(eject_valid), .eject_coin(eject_coin), .eject_ack(eject_ack), .refill(refill),
    .cnt5(cnt5), .cnt10(cnt10), .cnt20(cnt20), .owed(owed), .fault(fault), .done(done),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int owed;
    int c5;
    int c10;
    int c20;
    int item;
  } done_t;

  int    coin_q[$];
  done_t done_q[$];
  int    total = 0;
  int    bad = 0;
  int    m5, m10, m20, m_owed;
  bit    ack_en = 1'b1;
  bit    sb_off = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m5 = 8; m10 = 8; m20 = 8; m_owed = 0;
  endtask

  // Greedy payout computed directly from denominations and remaining stock.
  task automatic model_req(input int item, input int change);
    int    rem;
    done_t d;
    rem = change;
    forever begin
      if (rem >= 20 && m20 > 0)      begin coin_q.push_back(3); m20--; rem -= 20; end
      else if (rem >= 10 && m10 > 0) begin coin_q.push_back(2); m10--; rem -= 10; end
      else if (rem >= 5 && m5 > 0)   begin coin_q.push_back(1); m5--;  rem -= 5;  end
      else break;
    end
    m_owed = (m_owed + rem > 255) ? 255 : m_owed + rem;
    d.owed = m_owed; d.c5 = m5; d.c10 = m10; d.c20 = m20; d.item = item;
    done_q.push_back(d);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 500; i++) begin
      if (req_ready) return;
      @(posedge clk); #1;
    end
    $display("FAIL ready_timeout: got req_ready=0 expected 1 within 500 cycles");
    $fatal(1, "bench stopped on timeout");
  endtask

  task automatic issue(input int item, input int change, input bit track);
    wait_ready();
    if (track) model_req(item, change);
    req_valid  = 1'b1;
    req_item   = 2'(item);
    req_change = 8'(change);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_refill();
    wait_ready();
    refill = 1'b1;
    @(posedge clk); #1;
    refill = 1'b0;
    model_reset();
  endtask

  // Hopper responder: acks each presented coin after a random 0..3 cycle delay.
  int ack_wait = 0;
  initial begin
    eject_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      eject_ack = 1'b0;
      if (ack_en && eject_valid) begin
        if (ack_wait == 0) begin
          eject_ack = 1'b1;
          ack_wait  = $urandom_range(0, 3);
        end else begin
          ack_wait--;
        end
      end
    end
  end

  // Monitor: pops expectations when a coin is presented or a payout completes.
  bit prev_ev = 1'b0;
  int motor_cnt = 0;
  int motor_bad = 0;
  always @(negedge clk) begin
    if (sb_off || !reset_n) begin
      motor_cnt = 0;
      motor_bad = 0;
    end else begin
      if (eject_valid && !prev_ev) begin
        if (coin_q.size() == 0) chk("unexpected_coin", int'(eject_coin), 0);
        else chk("coin", int'(eject_coin), coin_q.pop_front());
      end
      if (motor_en) begin
        motor_cnt++;
        if (done_q.size() == 0 || int'(motor_item) != done_q[0].item) motor_bad++;
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          done_t d;
          d = done_q.pop_front();
          chk("done_owed", int'(owed), d.owed);
          chk("done_cnt5", int'(cnt5), d.c5);
          chk("done_cnt10", int'(cnt10), d.c10);
          chk("done_cnt20", int'(cnt20), d.c20);
          chk("motor_cycles", motor_cnt, (d.item != 0) ? 4 : 0);
          chk("motor_item_bad", motor_bad, 0);
        end
        motor_cnt = 0;
        motor_bad = 0;
      end
    end
    prev_ev = eject_valid;
  end

  initial begin
    int mot_bits, dn_bits, rdy_bits, ev_cnt, rise;
    bit pv;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_item   = '0;
    req_change = '0;
    refill     = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_cnt5", int'(cnt5), 8);
    chk("rst_cnt10", int'(cnt10), 8);
    chk("rst_cnt20", int'(cnt20), 8);
    chk("rst_owed", int'(owed), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_state", int'(state_out), 0);
    chk("rst_drive", int'({motor_en, eject_valid, done}), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Motor latency with no change: motor T+1..T+4, done T+6, ready T+7.
    issue(1, 0, 1);
    mot_bits = 0; dn_bits = 0; rdy_bits = 0; ev_cnt = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      mot_bits |= int'(motor_en) << (k - 1);
      dn_bits  |= int'(done) << (k - 1);
      rdy_bits |= int'(req_ready) << (k - 1);
      ev_cnt   += int'(eject_valid);
    end
    chk("lat_motor", mot_bits, 'b0001111);
    chk("lat_done", dn_bits, 'b0100000);
    chk("lat_ready", rdy_bits, 'b1000000);
    chk("lat_no_eject", ev_cnt, 0);
    wait_ready();
    chk("lat_state_idle", int'(state_out), 0);

    issue(2, 35, 1);
    wait_ready();

    // Drain the 20 hopper: the ninth payout of 20 falls back to two 10s.
    do_refill();
    for (int n = 0; n < 9; n++) begin
      issue(0, 20, 1);
      wait_ready();
    end
    chk("drain_cnt20", int'(cnt20), 0);
    chk("drain_cnt10", int'(cnt10), 6);

    do_refill();
    issue(0, 13, 1);
    wait_ready();
    chk("odd_owed", int'(owed), 3);

    // Hopper timeout.
    do_refill();
    sb_off = 1'b1;
    ack_en = 1'b0;
    issue(0, 15, 0);
    ev_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (eject_valid) ev_cnt++;
      if (state_out == 3'd5) break;
    end
    chk("to_valid_cycles", ev_cnt, 16);
    chk("to_fault", int'(fault), 1);
    chk("to_owed", int'(owed), 15);
    chk("to_state", int'(state_out), 5);
    chk("to_cnt10", int'(cnt10), 8);
    chk("to_ready", int'(req_ready), 0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_item = 2'd1; req_change = 8'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("to_req_ignored", int'(state_out), 5);
    chk("to_motor_off", int'(motor_en), 0);
    req_valid = 1'b0;
    refill = 1'b1;
    @(posedge clk); #1;
    refill = 1'b0;
    chk("rf_fault", int'(fault), 0);
    chk("rf_owed", int'(owed), 0);
    chk("rf_cnt", int'({cnt5, cnt10, cnt20}), 'h888);
    chk("rf_state", int'(state_out), 0);
    model_reset();
    ack_en = 1'b1;
    @(negedge clk);
    sb_off = 1'b0;

    // Reset during the second ejection of a 40 payout.
    sb_off = 1'b1;
    issue(0, 40, 0);
    rise = 0; pv = 1'b0;
    for (int i = 0; i < 200 && rise < 2; i++) begin
      if (eject_valid && !pv) rise++;
      pv = eject_valid;
      if (rise < 2) begin @(posedge clk); #1; end
    end
    chk("mid_rises", rise, 2);
    reset_n = 1'b0;
    #1;
    chk("mid_eject_off", int'(eject_valid), 0);
    chk("mid_cnt20", int'(cnt20), 8);
    chk("mid_state", int'(state_out), 0);
    chk("mid_outs", int'({motor_en, done, fault}), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    sb_off = 1'b0;
    issue(0, 5, 1);
    wait_ready();

    // Randomized payouts with occasional refills.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) do_refill();
      issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 200)), 1);
      wait_ready();
    end

    @(negedge clk);
    chk("coin_q_empty", coin_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
